dyn_reconf_multi: RTL and testbench

//  Parametrised DRP register file and decoder for the simulated PLL/MMCM; successor to dyn_reconf.

---
 rtl/dyn_reconf_multi_pkg.sv | 42 ++++
 rtl/dyn_reconf_chan_decode.sv | 41 ++++
 rtl/dyn_reconf_multi.sv | 199 +++++++++++++++++++
 tb/tb_dyn_reconf_multi.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dyn_reconf_multi_pkg.sv
// Shared definitions for the DRP register file: address map, reset values,
// FSM encoding and small field helpers.
package dyn_reconf_multi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } drp_state_e;

   localparam logic [6:0] ADDR_FB_R1  = 7'h14;
   localparam logic [6:0] ADDR_FB_R2  = 7'h15;
   localparam logic [6:0] ADDR_DIVREG = 7'h16;

   localparam logic [15:0] CLKREG1_RST = 16'h0041;
   localparam logic [15:0] CLKREG2_RST = 16'h0040;
   localparam logic [15:0] DIVREG_RST  = 16'h1041;

   localparam logic [3:0] CHAN_NONE = 4'hF;

   // CLKOUT channels occupy register pairs; bit 0 of the address picks ClkReg2.
   function automatic logic [3:0] addr_chan(input logic [6:0] addr);
      logic [3:0] chan;
      case (addr[6:1])
         6'h03:   chan = 4'd5;
         6'h04:   chan = 4'd0;
         6'h05:   chan = 4'd1;
         6'h06:   chan = 4'd2;
         6'h07:   chan = 4'd3;
         6'h08:   chan = 4'd4;
         6'h09:   chan = 4'd6;
         default: chan = CHAN_NONE;
      endcase
      return chan;
   endfunction

   // A HIGH or LOW count of zero encodes 64.
   function automatic logic [6:0] field_count(input logic [5:0] f);
      return (f == 6'd0) ? 7'd64 : {1'b0, f};
   endfunction

endpackage

// File: rtl/dyn_reconf_chan_decode.sv
// Turns one ClkReg1/ClkReg2 pair into divide*1000, duty*1000 and phase (ps).
// Purely combinational; the top decides what gets registered.
module dyn_reconf_chan_decode
   import dyn_reconf_multi_pkg::*;
#(
   parameter bit FRAC_CAPABLE = 1'b0
) (
   input  logic [15:0] clkreg1_i,
   input  logic [15:0] clkreg2_i,
   input  logic [31:0] vco_period_1000_i,
   output logic [31:0] divide_1000_o,
   output logic [31:0] duty_1000_o,
   output logic [31:0] phase_1000_o
);

   logic [31:0] high;
   logic [31:0] low;
   logic [31:0] div;
   logic [31:0] frac_add;
   logic [31:0] phase_steps;
   logic        no_count;
   logic        unused_bits;

   assign high     = 32'(field_count(clkreg1_i[11:6]));
   assign low      = 32'(field_count(clkreg1_i[5:0]));
   assign div      = high + low;
   assign no_count = clkreg2_i[6];
   assign frac_add = (FRAC_CAPABLE && clkreg2_i[11]) ? 32'(clkreg2_i[14:12]) * 32'd125 : 32'd0;

   assign divide_1000_o = no_count ? 32'd1000 : div * 32'd1000 + frac_add;
   // Fractional part is deliberately left out of the duty computation.
   assign duty_1000_o   = no_count ? 32'd500 :
                          ((32'd2 * high + 32'(clkreg2_i[7])) * 32'd1000) / (32'd2 * div);

   // DELAY counts whole VCO periods, PHASE_MUX eighths of one.
   assign phase_steps  = 32'({clkreg2_i[5:0], clkreg1_i[15:13]});
   assign phase_1000_o = (phase_steps * vco_period_1000_i) / 32'd8;

   assign unused_bits = ^{clkreg1_i[12], clkreg2_i[15], clkreg2_i[10:8]};

endmodule

// File: rtl/dyn_reconf_multi.sv
// DRP register file with IDLE/BUSY/ACK handshake FSM, per-channel decoders
// and the DivReg decode for the simulated PLL/MMCM.
module dyn_reconf_multi
   import dyn_reconf_multi_pkg::*;
#(
   parameter int NUM_CLKOUT    = 7,
   parameter int DRDY_LATENCY  = 2,
   parameter int FRAC_EN_ALLOW = 1
) (
   input  logic                    DCLK,
   input  logic                    RST,
   input  logic                    PWRDWN,
   input  logic [31:0]             vco_period_1000,
   input  logic [6:0]              DADDR,
   input  logic                    DEN,
   input  logic                    DWE,
   input  logic [15:0]             DI,
   output logic [15:0]             DO,
   output logic                    DRDY,
   output logic                    DRP_ERR,
   output logic [32*NUM_CLKOUT-1:0] CLKOUT_DIVIDE_1000,
   output logic [32*NUM_CLKOUT-1:0] CLKOUT_DUTY_CYCLE_1000,
   output logic [32*NUM_CLKOUT-1:0] CLKOUT_PHASE_1000,
   output logic [31:0]             CLKFBOUT_MULT_F_1000,
   output logic [31:0]             CLKFBOUT_PHASE_1000,
   output logic [31:0]             DIVCLK_DIVIDE
);

   localparam logic [3:0] LAT_M1 = 4'(DRDY_LATENCY - 1);

   drp_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [6:0]  addr_q, addr_d;
   logic        we_q, we_d;
   logic [15:0] di_q, di_d;
   logic [15:0] do_q;
   logic        err_q;
   logic        ack;
   logic [3:0]  acc_chan;
   logic [15:0] rdata;

   logic [15:0] clkreg1_q [NUM_CLKOUT];
   logic [15:0] clkreg2_q [NUM_CLKOUT];
   logic [15:0] fb1_q, fb2_q, divreg_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      di_d    = di_q;
      case (state_q)
         ST_IDLE: begin
            if (DEN && !PWRDWN) begin
               addr_d  = DADDR;
               we_d    = DWE;
               di_d    = DI;
               cnt_d   = LAT_M1;
               state_d = (LAT_M1 == 4'd0) ? ST_ACK : ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = ST_ACK;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge DCLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 7'd0;
         we_q    <= 1'b0;
         di_q    <= 16'd0;
         do_q    <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         di_q    <= di_d;
         do_q    <= DO;
         err_q   <= DEN && !PWRDWN && (state_q != ST_IDLE);
      end
   end

   assign ack      = (state_q == ST_ACK);
   assign acc_chan = addr_chan(addr_q);
   assign DRDY     = ack;
   assign DRP_ERR  = err_q;
   // Read data is presented during ACK and held afterwards until the next read.
   assign DO       = (ack && !we_q) ? rdata : do_q;

   always_comb begin
      rdata = 16'd0;
      for (int n = 0; n < NUM_CLKOUT; n++) begin
         if (acc_chan == 4'(n)) rdata = addr_q[0] ? clkreg2_q[n] : clkreg1_q[n];
      end
      case (addr_q)
         ADDR_FB_R1:  rdata = fb1_q;
         ADDR_FB_R2:  rdata = fb2_q;
         ADDR_DIVREG: rdata = divreg_q;
         default:     ;
      endcase
   end

   always_ff @(posedge DCLK or posedge RST) begin
      if (RST) begin
         for (int n = 0; n < NUM_CLKOUT; n++) begin
            clkreg1_q[n] <= CLKREG1_RST;
            clkreg2_q[n] <= CLKREG2_RST;
         end
         fb1_q    <= CLKREG1_RST;
         fb2_q    <= CLKREG2_RST;
         divreg_q <= DIVREG_RST;
      end else if (ack && we_q) begin
         for (int n = 0; n < NUM_CLKOUT; n++) begin
            if (acc_chan == 4'(n)) begin
               if (addr_q[0]) clkreg2_q[n] <= di_q;
               else           clkreg1_q[n] <= di_q;
            end
         end
         case (addr_q)
            ADDR_FB_R1:  fb1_q    <= di_q;
            ADDR_FB_R2:  fb2_q    <= di_q;
            ADDR_DIVREG: divreg_q <= di_q;
            default:     ;
         endcase
      end
   end

   logic [31:0] chan_div   [NUM_CLKOUT];
   logic [31:0] chan_duty  [NUM_CLKOUT];
   logic [31:0] chan_phase [NUM_CLKOUT];
   logic [31:0] div_q      [NUM_CLKOUT];
   logic [31:0] duty_q     [NUM_CLKOUT];

   for (genvar n = 0; n < NUM_CLKOUT; n++) begin : g_chan
      dyn_reconf_chan_decode #(
         .FRAC_CAPABLE (n == 0 && FRAC_EN_ALLOW != 0)
      ) u_dec (
         .clkreg1_i         (clkreg1_q[n]),
         .clkreg2_i         (clkreg2_q[n]),
         .vco_period_1000_i (vco_period_1000),
         .divide_1000_o     (chan_div[n]),
         .duty_1000_o       (chan_duty[n]),
         .phase_1000_o      (chan_phase[n])
      );
      assign CLKOUT_DIVIDE_1000[32*n +: 32]     = div_q[n];
      assign CLKOUT_DUTY_CYCLE_1000[32*n +: 32] = duty_q[n];
      assign CLKOUT_PHASE_1000[32*n +: 32]      = chan_phase[n];
   end

   logic [31:0] fb_div, fb_duty;
   logic [31:0] mult_q, divclk_q, divclk_d;
   logic        unused_top;

   dyn_reconf_chan_decode #(
      .FRAC_CAPABLE (FRAC_EN_ALLOW != 0)
   ) u_fb_dec (
      .clkreg1_i         (fb1_q),
      .clkreg2_i         (fb2_q),
      .vco_period_1000_i (vco_period_1000),
      .divide_1000_o     (fb_div),
      .duty_1000_o       (fb_duty),
      .phase_1000_o      (CLKFBOUT_PHASE_1000)
   );

   assign divclk_d = divreg_q[12] ? 32'd1 :
                     32'(field_count(divreg_q[11:6])) + 32'(field_count(divreg_q[5:0]));

   // Phase stays combinational so it tracks vco_period_1000 directly.
   always_ff @(posedge DCLK or posedge RST) begin
      if (RST) begin
         for (int n = 0; n < NUM_CLKOUT; n++) begin
            div_q[n]  <= 32'd1000;
            duty_q[n] <= 32'd500;
         end
         mult_q   <= 32'd1000;
         divclk_q <= 32'd1;
      end else begin
         for (int n = 0; n < NUM_CLKOUT; n++) begin
            div_q[n]  <= chan_div[n];
            duty_q[n] <= chan_duty[n];
         end
         mult_q   <= fb_div;
         divclk_q <= divclk_d;
      end
   end

   assign CLKFBOUT_MULT_F_1000 = mult_q;
   assign DIVCLK_DIVIDE        = divclk_q;
   assign unused_top           = ^{fb_duty, divreg_q[15:13]};

endmodule

// File: tb/tb_dyn_reconf_multi.sv
// Bench for dyn_reconf_multi: a 7-channel instance and a 2-channel,
// non-fractional instance share one DRP bus; reads are scoreboarded.
module tb_dyn_reconf_multi;

   logic        DCLK = 1'b0;
   logic        RST, PWRDWN, DEN, DWE;
   logic [6:0]  DADDR;
   logic [15:0] DI;
   logic [31:0] vco;

   logic [15:0]  do1, do2;
   logic         drdy1, drdy2, err1, err2;
   logic [223:0] div1, duty1, ph1;
   logic [63:0]  div2, duty2, ph2;
   logic [31:0]  mult1, fbph1, divclk1, mult2, fbph2, divclk2;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp2_q[$];

   dyn_reconf_multi #(.NUM_CLKOUT(7), .DRDY_LATENCY(2), .FRAC_EN_ALLOW(1)) dut (
      .DCLK(DCLK), .RST(RST), .PWRDWN(PWRDWN), .vco_period_1000(vco),
      .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
      .DO(do1), .DRDY(drdy1), .DRP_ERR(err1),
      .CLKOUT_DIVIDE_1000(div1), .CLKOUT_DUTY_CYCLE_1000(duty1), .CLKOUT_PHASE_1000(ph1),
      .CLKFBOUT_MULT_F_1000(mult1), .CLKFBOUT_PHASE_1000(fbph1), .DIVCLK_DIVIDE(divclk1)
   );

   dyn_reconf_multi #(.NUM_CLKOUT(2), .DRDY_LATENCY(2), .FRAC_EN_ALLOW(0)) dut2 (
      .DCLK(DCLK), .RST(RST), .PWRDWN(PWRDWN), .vco_period_1000(vco),
      .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
      .DO(do2), .DRDY(drdy2), .DRP_ERR(err2),
      .CLKOUT_DIVIDE_1000(div2), .CLKOUT_DUTY_CYCLE_1000(duty2), .CLKOUT_PHASE_1000(ph2),
      .CLKFBOUT_MULT_F_1000(mult2), .CLKFBOUT_PHASE_1000(fbph2), .DIVCLK_DIVIDE(divclk2)
   );

   // ---------------- clock / reset ----------------
   always #5 DCLK = ~DCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   task automatic drp_txn(input logic [6:0] a, input logic we, input logic [15:0] d,
                          input logic [15:0] e1, input logic [15:0] e2);
      int cyc;
      logic [15:0] exp;
      @(negedge DCLK);
      DADDR = a; DWE = we; DI = d; DEN = 1'b1;
      if (!we) begin
         exp_q.push_back(e1);
         exp2_q.push_back(e2);
      end
      @(negedge DCLK);
      DEN = 1'b0;
      cyc = 1;
      while (!drdy1 && cyc < 20) begin
         @(negedge DCLK);
         cyc++;
      end
      checks++;
      if (drdy1 !== 1'b1) begin
         errors++;
         $display("FAIL drdy_timeout addr=%h: no DRDY within %0d cycles", a, cyc);
         if (!we) begin
            exp = exp_q.pop_front();
            exp = exp2_q.pop_front();
         end
      end else begin
         checks++;
         if (cyc !== 2) begin
            errors++;
            $display("FAIL drdy_latency addr=%h: got %0d cycles, want 2", a, cyc);
         end
         checks++;
         if (drdy2 !== 1'b1) begin
            errors++;
            $display("FAIL drdy2 addr=%h: got %b, want 1", a, drdy2);
         end
         if (!we) begin
            exp = exp_q.pop_front();
            checks++;
            if (do1 !== exp) begin
               errors++;
               $display("FAIL read_do addr=%h: got %h, want %h", a, do1, exp);
            end
            exp = exp2_q.pop_front();
            checks++;
            if (do2 !== exp) begin
               errors++;
               $display("FAIL read_do2 addr=%h: got %h, want %h", a, do2, exp);
            end
         end
      end
      @(negedge DCLK);
      checks++;
      if (drdy1 !== 1'b0) begin
         errors++;
         $display("FAIL drdy_width addr=%h: DRDY still %b one cycle later", a, drdy1);
      end
      @(negedge DCLK);
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RST = 1'b1; PWRDWN = 1'b0; DEN = 1'b0; DWE = 1'b0; DADDR = 7'd0; DI = 16'd0;
      vco = 32'd32000;
      repeat (3) @(negedge DCLK);
      checks++;
      if (do1 !== 16'd0 || drdy1 !== 1'b0 || err1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_drp: DO=%h DRDY=%b ERR=%b, want 0/0/0", do1, drdy1, err1);
      end
      check32("reset_div0", div1[31:0], 32'd1000);
      check32("reset_duty0", duty1[31:0], 32'd500);
      check32("reset_phase0", ph1[31:0], 32'd0);
      check32("reset_divclk", divclk1, 32'd1);
      check32("reset_mult", mult1, 32'd1000);
      RST = 1'b0;
      @(negedge DCLK);
   endtask

   task automatic test_clkout0_decode();
      drp_txn(7'h08, 1'b1, 16'h6183, 16'h0, 16'h0);
      check32("nocount_default_div", div1[31:0], 32'd1000);
      drp_txn(7'h08, 1'b0, 16'h0, 16'h6183, 16'h6183);
      drp_txn(7'h09, 1'b1, 16'h0000, 16'h0, 16'h0);
      check32("c0_div", div1[31:0], 32'd9000);
      check32("c0_duty", duty1[31:0], 32'd666);
      check32("c0_phase", ph1[31:0], 32'd12000);
   endtask

   task automatic test_edge_nocount();
      drp_txn(7'h09, 1'b1, 16'h0043, 16'h0, 16'h0);
      check32("nocount_div", div1[31:0], 32'd1000);
      check32("nocount_duty", duty1[31:0], 32'd500);
      check32("nocount_phase", ph1[31:0], 32'd108000);
      drp_txn(7'h09, 1'b1, 16'h0083, 16'h0, 16'h0);
      check32("edge_div", div1[31:0], 32'd9000);
      check32("edge_duty", duty1[31:0], 32'd722);
      check32("edge_phase", ph1[31:0], 32'd108000);
   endtask

   task automatic test_frac();
      drp_txn(7'h09, 1'b1, 16'h3800, 16'h0, 16'h0);
      check32("frac_div", div1[31:0], 32'd9375);
      check32("frac_duty", duty1[31:0], 32'd666);
      check32("frac_disabled_div", div2[31:0], 32'd9000);
      drp_txn(7'h14, 1'b1, 16'h6183, 16'h0, 16'h0);
      drp_txn(7'h15, 1'b1, 16'h3800, 16'h0, 16'h0);
      check32("fb_mult", mult1, 32'd9375);
      check32("fb_phase", fbph1, 32'd12000);
      vco = 32'd16000;
      #1;
      check32("vco_phase", ph1[31:0], 32'd6000);
      vco = 32'd32000;
   endtask

   task automatic test_divreg_unmapped();
      drp_txn(7'h16, 1'b1, 16'h00C3, 16'h0, 16'h0);
      check32("divclk", divclk1, 32'd6);
      drp_txn(7'h16, 1'b0, 16'h0, 16'h00C3, 16'h00C3);
      drp_txn(7'h0E, 1'b1, 16'h1234, 16'h0, 16'h0);
      drp_txn(7'h0E, 1'b0, 16'h0, 16'h1234, 16'h0000);
      drp_txn(7'h30, 1'b0, 16'h0, 16'h0000, 16'h0000);
   endtask

   task automatic test_back_to_back();
      int pulses;
      @(negedge DCLK);
      DADDR = 7'h0A; DWE = 1'b1; DI = 16'h0082; DEN = 1'b1;
      @(negedge DCLK);
      DADDR = 7'h0C; DI = 16'h0FFF;
      @(negedge DCLK);
      DEN = 1'b0;
      pulses = 0;
      checks++;
      if (err1 !== 1'b1 || drdy1 !== 1'b1) begin
         errors++;
         $display("FAIL busy_err: DRP_ERR=%b DRDY=%b, want 1/1", err1, drdy1);
      end
      for (int i = 0; i < 4; i++) begin
         if (drdy1 === 1'b1) pulses++;
         @(negedge DCLK);
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL busy_single_drdy: got %0d pulses, want 1", pulses);
      end
      checks++;
      if (err1 !== 1'b0) begin
         errors++;
         $display("FAIL busy_err_width: DRP_ERR=%b, want 0", err1);
      end
      drp_txn(7'h0A, 1'b0, 16'h0, 16'h0082, 16'h0082);
      drp_txn(7'h0C, 1'b0, 16'h0, 16'h0041, 16'h0000);
   endtask

   task automatic test_reset_mid();
      int pulses;
      @(negedge DCLK);
      DADDR = 7'h08; DWE = 1'b1; DI = 16'h0000; DEN = 1'b1;
      @(negedge DCLK);
      DEN = 1'b0; RST = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge DCLK);
         if (drdy1 === 1'b1) pulses++;
         if (i == 1) RST = 1'b0;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL rst_mid_drdy: got %0d pulses, want 0", pulses);
      end
      check32("rst_mid_div", div1[31:0], 32'd1000);
      check32("rst_mid_phase", ph1[31:0], 32'd0);
      check32("rst_mid_divclk", divclk1, 32'd1);
      drp_txn(7'h08, 1'b0, 16'h0, 16'h0041, 16'h0041);
   endtask

   task automatic test_pwrdwn();
      int pulses;
      PWRDWN = 1'b1;
      @(negedge DCLK);
      DADDR = 7'h08; DWE = 1'b1; DI = 16'h6183; DEN = 1'b1;
      @(negedge DCLK);
      DEN = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         if (drdy1 === 1'b1 || err1 === 1'b1) pulses++;
         @(negedge DCLK);
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL pwrdwn_drdy: got %0d DRDY/ERR cycles, want 0", pulses);
      end
      PWRDWN = 1'b0;
      drp_txn(7'h08, 1'b0, 16'h0, 16'h0041, 16'h0041);
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_clkout0_decode();
      test_edge_nocount();
      test_frac();
      test_divreg_unmapped();
      test_back_to_back();
      test_reset_mid();
      test_pwrdwn();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
